// File: rtl/cdc_channel_arbiter.sv
// Round-robin arbiter that serialises NUM_REQ requesters onto one handshake sender channel.
// Optional ack watchdog with sticky error and HALT state: define CDC_ARB_TIMEOUT_EN.
module cdc_channel_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int DATA_W         = 8,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_done,
    output logic                        hs_valid,
    output logic [DATA_W-1:0]           hs_data,
    input  logic                        hs_ack,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id,
    output logic                        busy,
    output logic                        err_timeout
);

    localparam int ID_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 16 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
        $error("cdc_channel_arbiter: unsupported NUM_REQ or TIMEOUT_CYCLES");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_SEND,
        S_WAIT_ACK,
        S_GUARD
`ifdef CDC_ARB_TIMEOUT_EN
        , S_HALT
`endif
    } state_t;

    state_t              state_q, state_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0]  req_done_q, req_done_d;
    logic                hs_valid_q, hs_valid_d;
    logic [DATA_W-1:0]   hs_data_q, hs_data_d;
    logic [ID_W-1:0]     grant_id_q, grant_id_d;
    logic                busy_q, busy_d;

    logic [DATA_W-1:0]   data_arr [NUM_REQ];
    logic [ID_W:0]       cand;
    logic [ID_W-1:0]     win_id;
    logic                win_found;

`ifdef CDC_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                err_q, err_d;
`endif

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            data_arr[i] = req_data[i*DATA_W +: DATA_W];
        end
    end

    // Search upward from rr_ptr with wrap; the first asserted request wins.
    always_comb begin
        // NOTE: every variable assigned here gets a default first, so no path can infer a latch.
        win_found = 1'b0;
        win_id    = '0;
        cand      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, rr_ptr_q} + (ID_W+1)'(i);
            if (cand >= (ID_W+1)'(NUM_REQ)) begin
                cand = cand - (ID_W+1)'(NUM_REQ);
            end
            if (!win_found && req_valid[cand[ID_W-1:0]]) begin
                win_found = 1'b1;
                win_id    = cand[ID_W-1:0];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        req_done_d = '0;
        hs_valid_d = 1'b0;
        hs_data_d  = hs_data_q;
        grant_id_d = grant_id_q;
`ifdef CDC_ARB_TIMEOUT_EN
        cnt_d      = cnt_q;
        err_d      = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (|req_valid) state_d = S_ARB;
            end
            S_ARB: begin
                if (win_found) begin
                    hs_data_d  = data_arr[win_id];
                    grant_id_d = win_id;
                    hs_valid_d = 1'b1;
                    state_d    = S_SEND;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SEND: begin
                state_d = S_WAIT_ACK;
`ifdef CDC_ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            S_WAIT_ACK: begin
                if (hs_ack) begin
                    req_done_d[grant_id_q] = 1'b1;
                    rr_ptr_d = (grant_id_q == ID_W'(NUM_REQ-1)) ? '0 : grant_id_q + ID_W'(1);
                    state_d  = S_GUARD;
                end
`ifdef CDC_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES-1)) begin
                    err_d   = 1'b1;
                    state_d = S_HALT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            S_GUARD: state_d = S_IDLE;
`ifdef CDC_ARB_TIMEOUT_EN
            // Channel level state is unknown after a lost ack; only reset recovers.
            S_HALT:  state_d = S_HALT;
`endif
            default: state_d = S_IDLE;
        endcase
        busy_d = state_d inside {S_ARB, S_SEND, S_WAIT_ACK};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            rr_ptr_q   <= '0;
            req_done_q <= '0;
            hs_valid_q <= 1'b0;
            hs_data_q  <= '0;
            grant_id_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all flops update from the same pre-edge values.
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            req_done_q <= req_done_d;
            hs_valid_q <= hs_valid_d;
            hs_data_q  <= hs_data_d;
            grant_id_q <= grant_id_d;
            busy_q     <= busy_d;
        end
    end

`ifdef CDC_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
    assign err_timeout = err_q;
`else
    assign err_timeout = 1'b0;
`endif

    assign req_done = req_done_q;
    assign hs_valid = hs_valid_q;
    assign hs_data  = hs_data_q;
    assign grant_id = grant_id_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_cdc_channel_arbiter.sv
// Self-checking bench for cdc_channel_arbiter: directed steps plus a randomized phase
// checked against a transfer-level round-robin model. Watchdog steps run with CDC_ARB_TIMEOUT_EN.
module tb_cdc_channel_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int TO = 16;

    logic             clk;
    logic             reset_n;
    logic [N-1:0]     req_valid;
    logic [N*W-1:0]   req_data;
    logic [N-1:0]     req_done;
    logic             hs_valid;
    logic [W-1:0]     hs_data;
    logic             hs_ack;
    logic [1:0]       grant_id;
    logic             busy;
    logic             err_timeout;

    logic [W-1:0]     dat [N];

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    // Random-phase model state
    bit           active;
    int           exp_launch, ack_cyc, idle_from, rr_m, eg;
    logic [W-1:0] ed;
    logic [N-1:0] exp_done;
    bit           exp_hs, exp_busy;
    int           at, last_done;

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign req_data[g*W +: W] = dat[g];
    end

    cdc_channel_arbiter #(
        .NUM_REQ(N),
        .DATA_W(W),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .req_valid(req_valid),
        .req_data(req_data),
        .req_done(req_done),
        .hs_valid(hs_valid),
        .hs_data(hs_data),
        .hs_ack(hs_ack),
        .grant_id(grant_id),
        .busy(busy),
        .err_timeout(err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_req_done"}, 32'(req_done), 0);
        check({tag, "_hs_valid"}, 32'(hs_valid), 0);
        check({tag, "_hs_data"}, 32'(hs_data), 0);
        check({tag, "_grant_id"}, 32'(grant_id), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_err_timeout"}, 32'(err_timeout), 0);
    endtask

    function automatic logic [N-1:0] one_hot(input int g);
        logic [N-1:0] r;
        r = '0;
        r[g] = 1'b1;
        return r;
    endfunction

    // Round-robin rule: first asserted request at or after the pointer, wrapping.
    function automatic int rr_pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    // Ticks `delay` cycles in WAIT_ACK checking frozen outputs, acks, then checks the done pulse.
    task automatic ack_and_done(input int delay, input int gid, input logic [W-1:0] d, input string tag);
        for (int k = 1; k <= delay; k++) begin
            tick();
            check({tag, "_hold_data"}, 32'(hs_data), 32'(d));
            check({tag, "_hold_grant"}, 32'(grant_id), 32'(gid));
            check({tag, "_hold_no_valid"}, 32'(hs_valid), 0);
            check({tag, "_hold_no_done"}, 32'(req_done), 0);
            check({tag, "_hold_busy"}, 32'(busy), 1);
        end
        hs_ack = 1'b1;
        tick();
        hs_ack = 1'b0;
        check({tag, "_done"}, 32'(req_done), 32'(one_hot(gid)));
    endtask

    task automatic wait_launch(input int limit, input string tag, output int when);
        when = -1;
        for (int k = 0; k < limit; k++) begin
            tick();
            if (hs_valid === 1'b1) begin
                when = cyc;
                return;
            end
            check({tag, "_no_done_before_launch"}, 32'(req_done), 0);
        end
        check({tag, "_launch_timeout"}, 32'(hs_valid), 1);
    endtask

    initial begin
        reset_n   = 1'b0;
        hs_ack    = 1'b0;
        req_valid = '0;
        for (int i = 0; i < N; i++) dat[i] = '0;
        repeat (3) tick();
        check_zero("reset");
        reset_n = 1'b1;
        tick();

        // Single request from requester 2
        for (int i = 0; i < N; i++) dat[i] = W'($urandom);
        dat[2]    = 8'hA5;
        req_valid = 4'b0100;
        tick();
        check("single_arb_no_valid", 32'(hs_valid), 0);
        check("single_arb_busy", 32'(busy), 1);
        tick();
        check("single_launch_valid", 32'(hs_valid), 1);
        check("single_launch_data", 32'(hs_data), 32'hA5);
        check("single_launch_grant", 32'(grant_id), 2);
        ack_and_done(10, 2, 8'hA5, "single");
        req_valid = '0;
        tick();
        check("single_done_one_cycle", 32'(req_done), 0);
        check("single_guard_not_busy", 32'(busy), 0);
        tick();

        // Pointer now at 3: requests 1001 must go 3 then 0, second launch at ack+4
        dat[3]    = W'($urandom);
        dat[0]    = W'($urandom);
        req_valid = 4'b1001;
        tick();
        tick();
        check("wrap_first_valid", 32'(hs_valid), 1);
        check("wrap_first_grant", 32'(grant_id), 3);
        check("wrap_first_data", 32'(hs_data), 32'(dat[3]));
        ack_and_done(3, 3, dat[3], "wrap_first");
        req_valid = 4'b0001;
        tick();
        check("wrap_gap_a2", 32'(hs_valid), 0);
        tick();
        check("wrap_gap_a3", 32'(hs_valid), 0);
        tick();
        check("wrap_second_valid_a4", 32'(hs_valid), 1);
        check("wrap_second_grant", 32'(grant_id), 0);
        check("wrap_second_data", 32'(hs_data), 32'(dat[0]));
        ack_and_done(2, 0, dat[0], "wrap_second");
        req_valid = '0;
        tick();
        tick();

        // Spurious acks in IDLE and in SEND
        hs_ack = 1'b1;
        tick();
        hs_ack = 1'b0;
        repeat (3) begin
            tick();
            check("spur_idle_no_done", 32'(req_done), 0);
            check("spur_idle_not_busy", 32'(busy), 0);
            check("spur_idle_no_valid", 32'(hs_valid), 0);
        end
        dat[1]    = W'($urandom);
        req_valid = 4'b0010;
        tick();
        tick();
        check("spur_send_valid", 32'(hs_valid), 1);
        check("spur_send_grant", 32'(grant_id), 1);
        hs_ack = 1'b1;
        tick();
        hs_ack = 1'b0;
        check("spur_send_no_done", 32'(req_done), 0);
        check("spur_send_still_busy", 32'(busy), 1);
        tick();
        check("spur_wait_no_done", 32'(req_done), 0);
        ack_and_done(2, 1, dat[1], "spur");
        req_valid = '0;
        tick();
        tick();

        // All four requesting continuously from reset, ack 5 cycles after each launch
        reset_n = 1'b0;
        for (int i = 0; i < N; i++) dat[i] = W'($urandom);
        req_valid = '1;
        tick();
        check_zero("reset_all4");
        reset_n   = 1'b1;
        last_done = -1;
        for (int k = 0; k < 5; k++) begin
            wait_launch(12, "rr", at);
            if (at < 0) break;
            check("rr_grant", 32'(grant_id), 32'(k % N));
            check("rr_data", 32'(hs_data), 32'(dat[k % N]));
            if (k > 0) check("rr_relaunch_gap", 32'(at - last_done), 3);
            ack_and_done(5, k % N, dat[k % N], "rr");
            last_done = cyc;
        end

        // Reset during WAIT_ACK: pointer would be 1, must restart at 0
        wait_launch(12, "rst", at);
        check("rst_pre_grant", 32'(grant_id), 1);
        tick();
        tick();
        reset_n = 1'b0;
        #1;
        check_zero("rst_async");
        tick();
        check_zero("rst_held");
        reset_n = 1'b1;
        wait_launch(12, "rst_after", at);
        check("rst_after_grant", 32'(grant_id), 0);
        check("rst_after_data", 32'(hs_data), 32'(dat[0]));
        ack_and_done(3, 0, dat[0], "rst_after");
        req_valid = '0;
        tick();
        tick();

        // Randomized traffic against the transfer-level model
        active    = 1'b0;
        rr_m      = 1;
        idle_from = cyc;
        eg        = 0;
        ed        = '0;
        exp_launch = 0;
        ack_cyc    = 0;
        for (int c = 0; c < 2000; c++) begin
            tick();
            exp_hs   = active && (cyc == exp_launch);
            exp_busy = active && (cyc >= exp_launch - 1) && (cyc <= ack_cyc);
            exp_done = (active && cyc == ack_cyc + 1) ? one_hot(eg) : '0;
            check("rnd_hs_valid", 32'(hs_valid), 32'(exp_hs));
            check("rnd_busy", 32'(busy), 32'(exp_busy));
            check("rnd_req_done", 32'(req_done), 32'(exp_done));
            if (active && cyc >= exp_launch && cyc <= ack_cyc) begin
                check("rnd_grant", 32'(grant_id), 32'(eg));
                check("rnd_data", 32'(hs_data), 32'(ed));
            end
            hs_ack = active && (cyc == ack_cyc);
            if (exp_done != '0) begin
                active    = 1'b0;
                rr_m      = (eg + 1) % N;
                idle_from = cyc + 1;
                if (c < 1800 && $urandom_range(1, 0) == 1) dat[eg] = W'($urandom);
                else req_valid[eg] = 1'b0;
            end
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && c < 1800 && $urandom_range(2, 0) == 0) begin
                    dat[i]       = W'($urandom);
                    req_valid[i] = 1'b1;
                end
            end
            if (!active && cyc >= idle_from && req_valid != '0) begin
                active     = 1'b1;
                exp_launch = cyc + 2;
                eg         = rr_pick(req_valid, rr_m);
                ed         = dat[eg];
                ack_cyc    = exp_launch + int'($urandom_range(6, 1));
            end
        end
        hs_ack    = 1'b0;
        req_valid = '0;
        tick();
        tick();
        check("rnd_end_idle", 32'(busy), 0);

`ifdef CDC_ARB_TIMEOUT_EN
        // Never ack: err_timeout after 16 WAIT_ACK cycles, then HALT ignores everything
        dat[0]    = W'($urandom);
        req_valid = 4'b0001;
        wait_launch(6, "to", at);
        check("to_grant", 32'(grant_id), 0);
        for (int k = 1; k <= TO; k++) begin
            tick();
            check("to_err_not_yet", 32'(err_timeout), 0);
            check("to_wait_busy", 32'(busy), 1);
        end
        tick();
        check("to_err_set", 32'(err_timeout), 1);
        check("to_halt_not_busy", 32'(busy), 0);
        req_valid = '1;
        repeat (20) begin
            tick();
            check("to_halt_no_valid", 32'(hs_valid), 0);
            check("to_halt_no_done", 32'(req_done), 0);
        end
        hs_ack = 1'b1;
        tick();
        hs_ack = 1'b0;
        tick();
        check("to_late_ack_no_done", 32'(req_done), 0);
        check("to_err_sticky", 32'(err_timeout), 1);
        check("to_late_ack_not_busy", 32'(busy), 0);
`else
        check("no_watchdog_err", 32'(err_timeout), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
